// File: rtl/uart_rx_ctrl_if.sv
// rtl/uart_rx_ctrl_if.sv - receiver-side configuration, control and FIFO signal bundle for uart_rx_ctrl
interface uart_rx_ctrl_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          Enable;
    logic [15:0]   BaudDiv;
    logic [3:0]    NBitsCfg;
    logic          Rx;
    logic          RxEn;
    logic          Tick;
    logic [3:0]    NBits;
    logic          RxDone;
    logic [7:0]    RxData;
    logic          RdEn;
    logic [7:0]    DataOut;
    logic          DataValid;
    logic [CW-1:0] Count;
    logic          Overrun;
    logic          OverrunClr;
    logic          Timeout;

    modport slave (
        input  Enable, BaudDiv, NBitsCfg, Rx, RxDone, RxData, RdEn, OverrunClr,
        output RxEn, Tick, NBits, DataOut, DataValid, Count, Overrun, Timeout
    );

    modport master (
        output Enable, BaudDiv, NBitsCfg, Rx, RxDone, RxData, RdEn, OverrunClr,
        input  RxEn, Tick, NBits, DataOut, DataValid, Count, Overrun, Timeout
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive sequencer: baud tick, frame FSM, show-ahead byte FIFO
// Optional idle timeout is built when RX_TIMEOUT_EN is defined.
module uart_rx_ctrl #(
    parameter int DEPTH    = 4,
    parameter int TO_TICKS = 640
) (
    input  logic          Clk,
    input  logic          Rst,
    uart_rx_ctrl_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TO_TICKS < 1) begin : g_bad_param
        $error("uart_rx_ctrl: DEPTH must be a power of 2 >= 2 and TO_TICKS >= 1");
    end

    typedef enum logic [1:0] {ST_OFF, ST_IDLE, ST_FRAME} state_t;

    state_t        state, state_nxt;
    logic          rx_s1, rx_s2;
    logic          done_s1, done_s2, done_s3;
    logic          done_rise;
    logic [15:0]   baud_cnt, div_m1;
    logic          tick;
    logic          rx_en, push;
    logic [3:0]    nbits_q, nbits_legal;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          empty, full, pop, wr_ok, ovr_set, overrun_q;

    // Line idles high, so the Rx synchroniser resets to 1 to avoid a false start bit
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            done_s1 <= 1'b0;
            done_s2 <= 1'b0;
            done_s3 <= 1'b0;
        end else begin
            rx_s1   <= bus.Rx;
            rx_s2   <= rx_s1;
            done_s1 <= bus.RxDone;
            done_s2 <= done_s1;
            done_s3 <= done_s2;
        end
    end

    assign done_rise = done_s2 & ~done_s3;

    assign div_m1 = (bus.BaudDiv < 16'd2) ? 16'd0 : bus.BaudDiv - 16'd1;
    assign tick   = (state != ST_OFF) && (baud_cnt >= div_m1);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)                                       baud_cnt <= 16'd0;
        else if (state == ST_OFF || state_nxt == ST_OFF) baud_cnt <= 16'd0;
        else if (tick)                                 baud_cnt <= 16'd0;
        else                                           baud_cnt <= baud_cnt + 16'd1;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state <= ST_OFF;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rx_en     = 1'b0;
        push      = 1'b0;
        case (state)
            ST_OFF: begin
                if (bus.Enable) state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                rx_en = 1'b1;
                if (!rx_s2)           state_nxt = ST_FRAME;
                else if (!bus.Enable) state_nxt = ST_OFF;
            end
            ST_FRAME: begin
                rx_en = 1'b1;
                if (done_rise) begin
                    push      = 1'b1;
                    state_nxt = bus.Enable ? ST_IDLE : ST_OFF;
                end
            end
            default: state_nxt = ST_OFF;
        endcase
    end

    assign nbits_legal = (bus.NBitsCfg == 4'd6 || bus.NBitsCfg == 4'd7 || bus.NBitsCfg == 4'd8)
                         ? bus.NBitsCfg : 4'd8;

    // Width tracks the config while idle and is frozen for the whole frame
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)                                              nbits_q <= 4'd8;
        else if ((state == ST_OFF && bus.Enable) || state == ST_IDLE) nbits_q <= nbits_legal;
    end

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign pop     = bus.RdEn && !empty;
    assign wr_ok   = push && (!full || pop);
    assign ovr_set = push && full && !pop;

    always_ff @(posedge Clk) begin
        if (wr_ok) mem[wr_ptr] <= bus.RxData;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            if (wr_ok && !pop)      count <= count + 1'b1;
            else if (!wr_ok && pop) count <= count - 1'b1;
            if (ovr_set)             overrun_q <= 1'b1;
            else if (bus.OverrunClr) overrun_q <= 1'b0;
        end
    end

`ifdef RX_TIMEOUT_EN
    localparam int TW = $clog2(TO_TICKS + 1);
    logic [TW-1:0] to_cnt;
    logic          timeout_q, to_clr;

    assign to_clr = pop || empty || (state_nxt == ST_FRAME && state != ST_FRAME);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            to_cnt    <= '0;
            timeout_q <= 1'b0;
        end else if (to_clr) begin
            to_cnt    <= '0;
            timeout_q <= 1'b0;
        end else if (state == ST_IDLE && tick && to_cnt != TW'(TO_TICKS)) begin
            to_cnt <= to_cnt + 1'b1;
            if (to_cnt == TW'(TO_TICKS - 1)) timeout_q <= 1'b1;
        end
    end

    assign bus.Timeout = timeout_q;
`else
    assign bus.Timeout = 1'b0;
`endif

    assign bus.RxEn      = rx_en;
    assign bus.Tick      = tick;
    assign bus.NBits     = nbits_q;
    assign bus.DataOut   = empty ? 8'h00 : mem[rd_ptr];
    assign bus.DataValid = !empty;
    assign bus.Count     = count;
    assign bus.Overrun   = overrun_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed table-driven bench for uart_rx_ctrl
module tb_uart_rx_ctrl;
    logic Clk = 1'b0;
    logic Rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 Clk = ~Clk;

    uart_rx_ctrl_if #(.DEPTH(4)) bus ();
    uart_rx_ctrl #(.DEPTH(4), .TO_TICKS(32)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));

    typedef struct {
        logic [15:0] bdiv;
        int          period;
    } tick_vec_t;

    typedef struct {
        logic [3:0] cfg;
        logic [7:0] data;
        logic [3:0] exp_nbits;
    } frame_vec_t;

    tick_vec_t  tv [5];
    frame_vec_t fv [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic nclk(input int n);
        repeat (n) @(negedge Clk);
    endtask

    // Start bit, then a receiver done pulse; optional pop / overrun clear on the push edge
    task automatic send_byte(input logic [7:0] data, input logic pop, input logic clr);
        logic [31:0] cnt_before;
        bus.Rx = 1'b0;
        nclk(4);
        bus.Rx = 1'b1;
        nclk(1);
        cnt_before = 32'(bus.Count);
        bus.RxData = data;
        bus.RxDone = 1'b1;
        nclk(2);
        chk("push_not_early", 32'(bus.Count), cnt_before);
        bus.RdEn       = pop;
        bus.OverrunClr = clr;
        nclk(1);
        bus.RdEn       = 1'b0;
        bus.OverrunClr = 1'b0;
        chk("push_valid", 32'(bus.DataValid), 32'd1);
        nclk(2);
        bus.RxDone = 1'b0;
        nclk(3);
    endtask

    task automatic pop_chk(input logic [7:0] exp);
        chk("pop_head", 32'(bus.DataOut), 32'(exp));
        bus.RdEn = 1'b1;
        nclk(1);
        bus.RdEn = 1'b0;
    endtask

    initial begin
        int k, p, nt;
        tv[0] = '{16'd4, 4};
        tv[1] = '{16'd0, 1};
        tv[2] = '{16'd1, 1};
        tv[3] = '{16'd3, 3};
        tv[4] = '{16'd7, 7};
        fv[0] = '{4'd7,  8'h55, 4'd7};
        fv[1] = '{4'd6,  8'hA3, 4'd6};
        fv[2] = '{4'd8,  8'hFF, 4'd8};
        fv[3] = '{4'd5,  8'h12, 4'd8};
        fv[4] = '{4'd15, 8'h80, 4'd8};
        fv[5] = '{4'd0,  8'h01, 4'd8};

        bus.Enable = 1'b0; bus.BaudDiv = 16'd4; bus.NBitsCfg = 4'd8; bus.Rx = 1'b1;
        bus.RxDone = 1'b0; bus.RxData = 8'h00; bus.RdEn = 1'b0; bus.OverrunClr = 1'b0;
        nclk(3);
        Rst = 1'b0;
        nclk(2);
        chk("rst_rxen", 32'(bus.RxEn), 0);
        chk("rst_nbits", 32'(bus.NBits), 8);
        chk("rst_dataout", 32'(bus.DataOut), 0);
        chk("rst_valid", 32'(bus.DataValid), 0);
        chk("rst_count", 32'(bus.Count), 0);
        chk("rst_overrun", 32'(bus.Overrun), 0);
        chk("rst_timeout", 32'(bus.Timeout), 0);
        nt = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.Tick) nt++;
            nclk(1);
        end
        chk("off_no_tick", 32'(nt), 0);

        bus.Enable = 1'b1;
        nclk(2);
        chk("idle_rxen", 32'(bus.RxEn), 1);
        for (int i = 0; i < 5; i++) begin
            bus.BaudDiv = tv[i].bdiv;
            nclk(20);
            k = 0;
            while (!bus.Tick && k < 40) begin nclk(1); k++; end
            chk($sformatf("tick_found_%0d", i), 32'(k < 40), 1);
            p = 0;
            do begin nclk(1); p++; end while (!bus.Tick && p < 40);
            chk($sformatf("tick_period_%0d", i), 32'(p), 32'(tv[i].period));
        end
        bus.BaudDiv = 16'd4;

        for (int i = 0; i < 6; i++) begin
            bus.NBitsCfg = fv[i].cfg;
            nclk(2);
            send_byte(fv[i].data, 1'b0, 1'b0);
            chk($sformatf("frm_nbits_%0d", i), 32'(bus.NBits), 32'(fv[i].exp_nbits));
            chk($sformatf("frm_data_%0d", i), 32'(bus.DataOut), 32'(fv[i].data));
            chk($sformatf("frm_count_%0d", i), 32'(bus.Count), 1);
            pop_chk(fv[i].data);
            chk($sformatf("frm_empty_%0d", i), 32'(bus.DataValid), 0);
            chk($sformatf("frm_out0_%0d", i), 32'(bus.DataOut), 0);
        end

        send_byte(8'h11, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0);
        send_byte(8'h33, 1'b0, 1'b0);
        send_byte(8'h44, 1'b0, 1'b0);
        chk("full_no_ovr", 32'(bus.Overrun), 0);
        send_byte(8'h55, 1'b0, 1'b0);
        chk("ovr_count", 32'(bus.Count), 4);
        chk("ovr_flag", 32'(bus.Overrun), 1);
        chk("ovr_head", 32'(bus.DataOut), 32'h11);
        bus.OverrunClr = 1'b1; nclk(1); bus.OverrunClr = 1'b0;
        chk("ovr_clr", 32'(bus.Overrun), 0);
        send_byte(8'h66, 1'b0, 1'b1);
        chk("ovr_wins_clr", 32'(bus.Overrun), 1);
        bus.OverrunClr = 1'b1; nclk(1); bus.OverrunClr = 1'b0;
        send_byte(8'h77, 1'b1, 1'b0);
        chk("fullpop_count", 32'(bus.Count), 4);
        chk("fullpop_ovr", 32'(bus.Overrun), 0);
        chk("fullpop_head", 32'(bus.DataOut), 32'h22);
        pop_chk(8'h22);
        pop_chk(8'h33);
        pop_chk(8'h44);
        pop_chk(8'h77);
        chk("drain_count", 32'(bus.Count), 0);
        bus.RdEn = 1'b1; nclk(2); bus.RdEn = 1'b0;
        chk("rd_empty_count", 32'(bus.Count), 0);
        chk("rd_empty_valid", 32'(bus.DataValid), 0);

        bus.NBitsCfg = 4'd6;
        nclk(3);
        bus.Rx = 1'b0;
        nclk(4);
        bus.NBitsCfg = 4'd7;
        bus.Enable = 1'b0;
        nclk(2);
        chk("frame_nbits_frozen", 32'(bus.NBits), 6);
        chk("frame_rxen_held", 32'(bus.RxEn), 1);
        bus.Rx = 1'b1;
        nclk(1);
        bus.RxData = 8'hC3;
        bus.RxDone = 1'b1;
        nclk(5);
        chk("endrop_rxen", 32'(bus.RxEn), 0);
        chk("endrop_count", 32'(bus.Count), 1);
        chk("endrop_data", 32'(bus.DataOut), 32'hC3);
        bus.RxDone = 1'b0;
        nclk(3);
        bus.Enable = 1'b1;
        nclk(2);
        chk("relatch_nbits", 32'(bus.NBits), 7);

        bus.Rx = 1'b0;
        nclk(4);
        Rst = 1'b1;
        nclk(1);
        chk("mrst_rxen", 32'(bus.RxEn), 0);
        chk("mrst_tick", 32'(bus.Tick), 0);
        chk("mrst_nbits", 32'(bus.NBits), 8);
        chk("mrst_dataout", 32'(bus.DataOut), 0);
        chk("mrst_valid", 32'(bus.DataValid), 0);
        chk("mrst_count", 32'(bus.Count), 0);
        chk("mrst_overrun", 32'(bus.Overrun), 0);
        bus.Rx = 1'b1;
        Rst = 1'b0;
        nclk(3);

`ifdef RX_TIMEOUT_EN
        bus.BaudDiv = 16'd1;
        send_byte(8'h5A, 1'b0, 1'b0);
        nclk(20);
        chk("to_not_yet", 32'(bus.Timeout), 0);
        nclk(25);
        chk("to_set", 32'(bus.Timeout), 1);
        pop_chk(8'h5A);
        chk("to_clr_pop", 32'(bus.Timeout), 0);
`else
        send_byte(8'h5A, 1'b0, 1'b0);
        nclk(50);
        chk("to_tied0", 32'(bus.Timeout), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
